// File: rtl/video_timing_pkg.sv
// Shared 1024x768@60 raster constants and types for the timing generator,
// sprite renderers and mixer.
package video_timing_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  // Matches the ROM plus colour-map latency of the sprite renderers.
  localparam int SYNC_DELAY = 2;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};

endpackage

// File: rtl/sync_delay_pipe.sv
// N-stage register delay with a parameterised reset value.
// Only present in builds with XVGA_SYNC_DELAY_EN defined.
`ifdef XVGA_SYNC_DELAY_EN
module sync_delay_pipe #(
  parameter int             W         = 1,
  parameter int             N         = 2,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         pixel_clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule
`endif

// File: rtl/xvga_timing.sv
// Raster timing generator: pixel/line counters, active-low syncs, blank and frame tick.
// Build option XVGA_SYNC_DELAY_EN delays hsync/vsync/blank by a 2-stage pipeline.
module xvga_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP     = video_timing_pkg::H_FP,
  parameter int H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int H_BP     = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP     = video_timing_pkg::V_FP,
  parameter int V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int V_BP     = video_timing_pkg::V_BP
) (
  input  logic                pixel_clk,
  input  logic                reset_n,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                frame_start,
  output logic [7:0]          frame_count
);

  localparam hcount_t H_LAST   = hcount_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam hcount_t H_VIS    = hcount_t'(H_ACTIVE);
  localparam hcount_t HS_FIRST = hcount_t'(H_ACTIVE + H_FP);
  localparam hcount_t HS_LAST  = hcount_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam vcount_t V_LAST   = vcount_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam vcount_t V_VIS    = vcount_t'(V_ACTIVE);
  localparam vcount_t VS_FIRST = vcount_t'(V_ACTIVE + V_FP);
  localparam vcount_t VS_LAST  = vcount_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  hcount_t h_nxt;
  vcount_t v_nxt;
  logic    h_wrap;
  logic    frame_wrap;
  sync_t   sync_nxt;
  sync_t   sync_q;
  sync_t   sync_out;

  // Sync/blank decode works on next-state counts so the registered flags line up with the counts.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    frame_wrap = h_wrap && (vcount == V_LAST);
    h_nxt      = h_wrap ? '0 : hcount + 1'b1;
    v_nxt      = vcount;
    if (h_wrap) v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    sync_nxt.hsync = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
    sync_nxt.vsync = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
    sync_nxt.blank = (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      sync_q      <= SYNC_IDLE;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      sync_q      <= sync_nxt;
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + 1'b1;
    end
  end

`ifdef XVGA_SYNC_DELAY_EN
  sync_delay_pipe #(
    .W         ($bits(sync_t)),
    .N         (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .d         (sync_q),
    .q         (sync_out)
  );
`else
  assign sync_out = sync_q;
`endif

  assign hsync = sync_out.hsync;
  assign vsync = sync_out.vsync;
  assign blank = sync_out.blank;

endmodule

// File: tb/tb_xvga_timing.sv
// Self-checking bench for xvga_timing: a reduced-timing instance checked cycle by cycle
// against a scoreboard model, plus a default-timing instance checked over one line.
`timescale 1ns/1ps
module tb_xvga_timing;

  localparam int SH_ACT = 10, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
  localparam int SH_TOT = SH_ACT + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_ACT = 6, SV_FP = 1, SV_SYNC = 2, SV_BP = 2;
  localparam int SV_TOT = SV_ACT + SV_FP + SV_SYNC + SV_BP;
  localparam int FRAME  = SH_TOT * SV_TOT;
`ifdef XVGA_SYNC_DELAY_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int   h;
    logic hs;
    logic bl;
  } vec_t;

  localparam obs_t RST_OBS = '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, fc: 8'd0};

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;

  logic [10:0] s_h,  d_h;
  logic [9:0]  s_v,  d_v;
  logic        s_hs, d_hs, s_vs, d_vs, s_bl, d_bl, s_fs, d_fs;
  logic [7:0]  s_fc, d_fc;

  xvga_timing #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) dut_s (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .hcount(s_h), .vcount(s_v),
    .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .frame_start(s_fs), .frame_count(s_fc)
  );

  xvga_timing dut_d (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .frame_start(d_fs), .frame_count(d_fc)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t obs_s();
    return '{h: s_h, v: s_v, hs: s_hs, vs: s_vs, bl: s_bl, fs: s_fs, fc: s_fc};
  endfunction

  function automatic obs_t obs_d();
    return '{h: d_h, v: d_v, hs: d_hs, vs: d_vs, bl: d_bl, fs: d_fs, fc: d_fc};
  endfunction

  function automatic logic [2:0] base_sync(input int h, input int v);
    logic hs, vs, bl;
    hs = !(h >= SH_ACT + SH_FP && h <= SH_ACT + SH_FP + SH_SYNC - 1);
    vs = !(v >= SV_ACT + SV_FP && v <= SV_ACT + SV_FP + SV_SYNC - 1);
    bl = (h >= SH_ACT) || (v >= SV_ACT);
    return {hs, vs, bl};
  endfunction

  // Reference model of the reduced-timing instance; expected values queued per clock.
  int         mh = 0, mv = 0;
  logic [7:0] mfc = 8'd0;
  logic       mfs = 1'b0;
  logic [2:0] hist [0:2] = '{3'b110, 3'b110, 3'b110};
  obs_t       sb_q [$];

  initial forever begin
    @(posedge pixel_clk or negedge reset_n);
    if (!reset_n) begin
      mh = 0; mv = 0; mfc = 8'd0; mfs = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = 3'b110;
      sb_q.delete();
    end else begin
      mfs = 1'b0;
      if (mh == SH_TOT - 1) begin
        mh = 0;
        if (mv == SV_TOT - 1) begin
          mv = 0; mfs = 1'b1; mfc = mfc + 8'd1;
        end else mv = mv + 1;
      end else mh = mh + 1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = base_sync(mh, mv);
      sb_q.push_back({11'(mh), 10'(mv), hist[SD], mfs, mfc});
    end
  end

  initial forever begin
    obs_t e;
    @(negedge pixel_clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scoreboard", 64'(obs_s()), 64'(e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    bit   done [8];
    int   seq_err, hs_low, hs_first, bl_first, v_before, v_after, prev_h, prev_v;
    int   fs_cnt, vs_low, vs_first;
    bit   found;

    tbl[0] = '{0,    1'b1, 1'b0};
    tbl[1] = '{1023, 1'b1, 1'b0};
    tbl[2] = '{1024, 1'b1, 1'b1};
    tbl[3] = '{1047, 1'b1, 1'b1};
    tbl[4] = '{1048, 1'b0, 1'b1};
    tbl[5] = '{1183, 1'b0, 1'b1};
    tbl[6] = '{1184, 1'b1, 1'b1};
    tbl[7] = '{1340, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) done[i] = 1'b0;

    repeat (3) @(negedge pixel_clk);
    check("reset_small",   64'(obs_s()), 64'(RST_OBS));
    check("reset_default", 64'(obs_d()), 64'(RST_OBS));
    reset_n = 1'b1;

    // One full line of the default-timing instance.
    seq_err = 0; hs_low = 0; hs_first = -1; bl_first = -1;
    v_before = -1; v_after = -1; prev_h = 0; prev_v = 0;
    for (int cyc = 0; cyc < 1400; cyc++) begin
      @(negedge pixel_clk);
      if (cyc == 0) check("default_first_h", 64'(d_h), 64'd1);
      if (cyc > 0) begin
        if (int'(d_h) != ((prev_h == 1343) ? 0 : prev_h + 1)) seq_err++;
        if (prev_h == 1343 && v_after < 0) begin
          v_before = prev_v;
          v_after  = int'(d_v);
        end
      end
      if (cyc < 1344) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_h);
        end
        if (d_bl && bl_first < 0) bl_first = int'(d_h);
      end
      for (int i = 0; i < 8; i++) begin
        if (!done[i] && int'(d_h) == tbl[i].h + SD) begin
          done[i] = 1'b1;
          check($sformatf("tbl_hsync_h%0d", tbl[i].h), 64'(d_hs), 64'(tbl[i].hs));
          check($sformatf("tbl_blank_h%0d", tbl[i].h), 64'(d_bl), 64'(tbl[i].bl));
        end
      end
      prev_h = int'(d_h);
      prev_v = int'(d_v);
    end
    for (int i = 0; i < 8; i++) check($sformatf("tbl_reached_%0d", i), 64'(done[i]), 64'd1);
    check("hcount_sequence_errors", 64'(seq_err),  64'd0);
    check("vcount_before_wrap",     64'(v_before), 64'd0);
    check("vcount_after_wrap",      64'(v_after),  64'd1);
    check("hsync_low_cycles",       64'(hs_low),   64'd136);
    check("hsync_first_low_h",      64'(hs_first), 64'(1048 + SD));
    check("blank_first_high_h",     64'(bl_first), 64'(1024 + SD));

    // Mid-frame asynchronous reset of the reduced-timing instance.
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge pixel_clk);
      if (s_h == 11'd5 && s_v == 10'd3) found = 1'b1;
    end
    check("mid_frame_reached", 64'(found), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_small",   64'(obs_s()), 64'(RST_OBS));
    check("async_reset_default", 64'(obs_d()), 64'(RST_OBS));
    repeat (2) @(negedge pixel_clk);
    check("held_reset_small", 64'(obs_s()), 64'(RST_OBS));
    reset_n = 1'b1;

    // 256 frames from reset: pulse count, frame_count wrap, vsync window.
    fs_cnt = 0; vs_low = 0; vs_first = -1;
    for (int e = 1; e <= 256 * FRAME; e++) begin
      @(negedge pixel_clk);
      if (s_fs) fs_cnt++;
      if (e <= FRAME && !s_vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(s_v);
      end
      if (e == 1) begin
        check("restart_h", 64'(s_h), 64'd1);
        check("no_fs_after_reset", 64'(s_fs), 64'd0);
      end
      if (e == FRAME - 1) check("no_fs_before_wrap", 64'(s_fs), 64'd0);
      if (e == FRAME) begin
        check("fs_at_wrap", 64'(s_fs), 64'd1);
        check("counts_at_wrap", 64'({s_h, s_v}), 64'd0);
        check("fc_one_frame", 64'(s_fc), 64'd1);
      end
    end
    check("fs_pulse_count", 64'(fs_cnt),   64'd256);
    check("fc_wrapped",     64'(s_fc),     64'd0);
    check("vsync_low_cycles", 64'(vs_low), 64'(SV_SYNC * SH_TOT));
    check("vsync_first_line", 64'(vs_first), 64'(SV_ACT + SV_FP));

    @(negedge pixel_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xvga_timing.md
XVGA_TIMING -- requirements
Module: xvga_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 160, horizontal back porch (H_TOTAL = 1344).
REQ-005 The block SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 The block SHALL have parameters V_FP 3, V_SYNC 6 and V_BP 29, vertical porches and sync in lines (V_TOTAL = 806).
REQ-007 pixel_clk  input  1  pixel clock, 65 MHz nominal; the only clock.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 hcount  output  11  current pixel column, 0..H_TOTAL-1.
REQ-010 vcount  output  10  current line, 0..V_TOTAL-1.
REQ-011 hsync  output  1  horizontal sync, active-low.
REQ-012 vsync  output  1  vertical sync, active-low.
REQ-013 blank  output  1  high outside the visible area.
REQ-014 frame_start  output  1  one-cycle pulse at the first pixel of each frame.
REQ-015 frame_count  output  8  frames elapsed since reset, used for blink and countdown timing.

Function
REQ-016 hcount SHALL increment by 1 every pixel_clk and wrap from H_TOTAL-1 to 0.
REQ-017 vcount SHALL increment only on the cycle hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 when hcount also wraps.
REQ-018 blank SHALL be 1 exactly when hcount >= H_ACTIVE or vcount >= V_ACTIVE, in the same cycle as the counts.
REQ-019 hsync SHALL be 0 exactly when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1048,1183] by default.
REQ-020 vsync SHALL be 0 exactly when vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [771,776] by default, for whole lines.
REQ-021 hsync, vsync and blank SHALL be registered, computed from next-state counts, and aligned with hcount and vcount with zero cycle offset.
REQ-022 frame_start SHALL be 1 for exactly the one cycle where hcount=0 and vcount=0 after a wrap; it SHALL NOT assert on the first cycle after reset.
REQ-023 frame_count SHALL increment by 1 on each frame_start and wrap from 255 to 0 modulo 2^8.
REQ-024 All widths SHALL be fixed: counts compare unsigned, and parameters exceeding the 11-bit or 10-bit range are illegal.

Reset
REQ-025 While reset_n=0 the outputs SHALL be: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_count=0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately (asynchronous) and abandon the frame with no frame_start.
REQ-027 Counting SHALL resume from (0,0) on the first pixel_clk edge after reset_n rises.

Configuration
REQ-028 Macro XVGA_SYNC_DELAY_EN SHALL control the sync/blank delay feature.
REQ-029 With XVGA_SYNC_DELAY_EN defined, hsync, vsync and blank SHALL be delayed by a 2-stage register pipeline relative to hcount and vcount, matching the 2-cycle ROM and colour-map latency of the sprite renderers.
REQ-030 Delay pipeline stages SHALL reset to 1, 1 and 0 for hsync, vsync and blank respectively.
REQ-031 Without XVGA_SYNC_DELAY_EN, the behaviour of REQ-021 SHALL apply.
REQ-032 frame_start and frame_count SHALL be undelayed in both builds.

Structure
REQ-033 The 1024x768@60 timing constants (H_ACTIVE..V_BP and H_TOTAL/V_TOTAL) SHALL live in shared package video_timing_pkg, for use by the renderers and the mixer.
REQ-034 No sub-module is required, except an optional sync_delay_pipe (N-stage register with parameterised reset value) used only when XVGA_SYNC_DELAY_EN is defined.

Verification
REQ-035 Release reset and run 1344 clocks: hcount sequences 0..1343 then 0, vcount goes 0 to 1 at the wrap, and blank=1 for exactly hcount 1024..1343.
REQ-036 Over one line, hsync=0 for exactly 136 cycles, starting at hcount=1048.
REQ-037 Run one full frame (1344x806 clocks): vsync=0 for lines 771..776, frame_start pulses once at (0,0) after the wrap, and frame_count=1.
REQ-038 Run 256 frames from reset: frame_count returns to 0, with exactly 256 frame_start pulses.
REQ-039 Assert reset_n=0 at hcount=500, vcount=300: outputs take reset values asynchronously, then restart at (0,0) with no frame_start.
REQ-040 With XVGA_SYNC_DELAY_EN defined: hsync falls 2 cycles after hcount=1048, and blank rises 2 cycles after hcount=1024.
